// File: rtl/npc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the NPC core with halt detection and counters.
// Optional single-step mode (step_req input, STEP_WAIT state) is enabled by defining NPC_SEQ_SINGLE_STEP_EN.
module npc_seq_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = 32'h8000_0000,
    parameter int              IMEM_TIMEOUT = 255,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_rsp_valid,
    output logic             imem_rsp_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  next_pc,
    input  logic             dec_illegal,
    input  logic             dec_wb_en,
    output logic             ex_start,
    input  logic             ex_done,
    output logic             rf_we,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`ifdef NPC_SEQ_SINGLE_STEP_EN
    ,
    input  logic             step_req
`endif
);

    localparam int          TO_W   = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT + 1);
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        ST_FETCH_REQ  = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXECUTE    = 3'd3,
        ST_WRITEBACK  = 3'd4,
        ST_HALT       = 3'd5
`ifdef NPC_SEQ_SINGLE_STEP_EN
        ,
        ST_STEP_WAIT  = 3'd6
`endif
    } state_t;

`ifdef NPC_SEQ_SINGLE_STEP_EN
    localparam state_t ST_IDLE = ST_STEP_WAIT;
`else
    localparam state_t ST_IDLE = ST_FETCH_REQ;
`endif

    state_t            state_r;
    state_t            state_nxt_s;
    logic [XLEN-1:0]   pc_r;
    logic [31:0]       ir_r;
    logic [1:0]        halt_code_r;
    logic              halted_r;
    logic [CNT_W-1:0]  cycle_cnt_r;
    logic [CNT_W-1:0]  instret_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              ex_start_r;
    logic              req_fire_s;
    logic              to_expire_s;
    logic              is_ebreak_s;

    assign req_fire_s  = imem_req_valid && imem_req_ready;
    assign to_expire_s = (to_cnt_r == TO_W'(IMEM_TIMEOUT - 1));
    assign is_ebreak_s = (ir_r == EBREAK);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an unknown encoding parks the core in HALT
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH_REQ: begin
                if (req_fire_s) state_nxt_s = ST_FETCH_WAIT;
                else            state_nxt_s = ST_FETCH_REQ;
            end
            ST_FETCH_WAIT: begin
                if (imem_rsp_valid)   state_nxt_s = ST_DECODE;
                else if (to_expire_s) state_nxt_s = ST_HALT;
                else                  state_nxt_s = ST_FETCH_WAIT;
            end
            ST_DECODE: begin
                if (is_ebreak_s || dec_illegal) state_nxt_s = ST_HALT;
                else                            state_nxt_s = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (ex_done) state_nxt_s = ST_WRITEBACK;
                else         state_nxt_s = ST_EXECUTE;
            end
            ST_WRITEBACK: state_nxt_s = ST_IDLE;
            ST_HALT:      state_nxt_s = ST_HALT;
`ifdef NPC_SEQ_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (step_req) state_nxt_s = ST_FETCH_REQ;
                else          state_nxt_s = ST_STEP_WAIT;
            end
`endif
            default:      state_nxt_s = ST_HALT;
        endcase
    end

    // PC, IR, halt status, timeout and counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r        <= RESET_PC;
            ir_r        <= 32'h0000_0000;
            halt_code_r <= 2'd0;
            halted_r    <= 1'b0;
            cycle_cnt_r <= {CNT_W{1'b0}};
            instret_r   <= {CNT_W{1'b0}};
            to_cnt_r    <= {TO_W{1'b0}};
            ex_start_r  <= 1'b0;
        end else begin
            halted_r   <= (state_nxt_s == ST_HALT);
            ex_start_r <= (state_nxt_s == ST_EXECUTE) && (state_r != ST_EXECUTE);
            if (state_r != ST_HALT) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
            end
            case (state_r)
                ST_FETCH_REQ: to_cnt_r <= {TO_W{1'b0}};
                ST_FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        ir_r <= imem_rdata;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                        if (to_expire_s) halt_code_r <= 2'd2;
                    end
                end
                // ebreak retires and wins over the illegal flag
                ST_DECODE: begin
                    if (is_ebreak_s) begin
                        halt_code_r <= 2'd1;
                        instret_r   <= instret_r + CNT_W'(1);
                    end else if (dec_illegal) begin
                        halt_code_r <= 2'd3;
                    end
                end
                ST_WRITEBACK: begin
                    pc_r      <= next_pc;
                    instret_r <= instret_r + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; handshakes and pulses forced low while rst is asserted
    always_comb begin
        imem_req_valid = 1'b0;
        imem_rsp_ready = 1'b0;
        rf_we          = 1'b0;
        ex_start       = 1'b0;
        if (rst) begin
            imem_req_valid = (state_r == ST_FETCH_REQ);
            imem_rsp_ready = (state_r == ST_FETCH_WAIT);
            rf_we          = (state_r == ST_WRITEBACK) && dec_wb_en;
            ex_start       = ex_start_r;
        end else begin
            imem_req_valid = 1'b0;
        end
        imem_addr   = pc_r;
        pc          = pc_r;
        ir          = ir_r;
        halted      = halted_r;
        halt_code   = halt_code_r;
        cycle_cnt   = cycle_cnt_r;
        instret_cnt = instret_r;
    end

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Scoreboard bench for npc_seq_ctrl: a behavioural instruction memory and EXU answer the DUT,
// expected fetch addresses, IR values, writebacks and halts are queued and checked by a monitor.
module tb_npc_seq_ctrl;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_ready;
    logic [31:0] imem_addr, imem_rdata, ir, pc, next_pc;
    logic        dec_illegal, dec_wb_en, ex_start, ex_done, rf_we, halted;
    logic [1:0]  halt_code;
    logic [31:0] cycle_cnt, instret_cnt;
`ifdef NPC_SEQ_SINGLE_STEP_EN
    logic        step_req = 1'b1;
`endif

    npc_seq_ctrl #(.XLEN(32), .RESET_PC(RST_PC), .IMEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc), .next_pc(next_pc), .dec_illegal(dec_illegal), .dec_wb_en(dec_wb_en),
        .ex_start(ex_start), .ex_done(ex_done), .rf_we(rf_we), .halted(halted), .halt_code(halt_code),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`ifdef NPC_SEQ_SINGLE_STEP_EN
        , .step_req(step_req)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; int ex_len; int fetch_len; } wb_exp_t;
    typedef struct { logic [1:0] code; logic [31:0] pc; logic [31:0] instret; int delta; } halt_exp_t;

    logic [31:0] addr_q[$];
    logic [31:0] ir_q[$];
    wb_exp_t     wb_q[$];
    halt_exp_t   halt_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Memory / EXU model configuration, written only by the stimulus process
    logic [31:0] instr_cfg = 32'h0;
    int          req_stall_cfg = 0;
    int          ex_stall_cfg = 0;
    int          grant = 0;
    logic        rsp_en = 1'b1;
    logic        rsp_force = 1'b0;

    // Memory / EXU model state, written only by the clocked model process
    int   taken = 0;
    int   hold_cnt = 0;
    int   ex_cnt = 0;
    int   cyc = 0;
    logic rsp_pending = 1'b0;

    always_comb begin
        imem_req_ready = (taken < grant) && (hold_cnt >= req_stall_cfg);
        imem_rsp_valid = (rsp_pending && rsp_en) || rsp_force;
        imem_rdata     = rsp_force ? 32'hDEAD_BEEF : instr_cfg;
        ex_done        = ex_start ? (ex_stall_cfg == 0) : (ex_cnt >= ex_stall_cfg);
    end

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        ex_cnt <= ex_start ? 1 : ex_cnt + 1;
        if (!rst) begin
            hold_cnt    <= 0;
            rsp_pending <= 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                hold_cnt    <= 0;
                taken       <= taken + 1;
                rsp_pending <= 1'b1;
            end else begin
                if (imem_req_valid && taken < grant) hold_cnt <= hold_cnt + 1;
                if (imem_rsp_valid && imem_rsp_ready) rsp_pending <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT event with no queued expectation (got 1, required 0)", name);
    endtask

    // Monitor: pop and compare whenever the DUT presents a fetch, execute start, writeback or halt
    int   hs_cyc = 0;
    int   ex_cyc = 0;
    logic halted_prev = 1'b0;
    always @(negedge clk) begin
        halted_prev <= halted;
        if (rst) begin
            if (imem_req_valid && imem_req_ready) begin
                hs_cyc <= cyc;
                if (addr_q.size() == 0) unexpected("fetch");
                else chk("fetch_addr", imem_addr, addr_q.pop_front());
            end
            if (ex_start) begin
                ex_cyc <= cyc;
                if (ir_q.size() == 0) unexpected("ex_start");
                else chk("ir_at_exec", ir, ir_q.pop_front());
            end
            if (rf_we) begin
                if (wb_q.size() == 0) unexpected("rf_we");
                else begin
                    wb_exp_t w;
                    w = wb_q.pop_front();
                    chk("wb_pc", pc, w.pc);
                    chk("exec_len", 64'(cyc - ex_cyc), 64'(w.ex_len));
                    chk("fetch_to_wb", 64'(cyc - hs_cyc), 64'(w.fetch_len));
                end
            end
            if (halted && !halted_prev) begin
                if (halt_q.size() == 0) unexpected("halt");
                else begin
                    halt_exp_t h;
                    h = halt_q.pop_front();
                    chk("halt_code", halt_code, h.code);
                    chk("halt_pc", pc, h.pc);
                    chk("halt_instret", instret_cnt, h.instret);
                    chk("fetch_to_halt", 64'(cyc - hs_cyc), 64'(h.delta));
                end
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [31:0] npc, input logic wb,
                         input logic ill, input int rstall, input int xstall);
        @(posedge clk); #1;
        instr_cfg     = instr;
        next_pc       = npc;
        dec_wb_en     = wb;
        dec_illegal   = ill;
        req_stall_cfg = rstall;
        ex_stall_cfg  = xstall;
        grant         = grant + 1;
    endtask

    task automatic wait_done(input logic [31:0] ret0, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instret_cnt == ret0 && !halted && n < 60);
        chk({"progress_", name}, 64'(n < 60), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        addr_q.delete(); ir_q.delete(); wb_q.delete(); halt_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic check_frozen(input logic [31:0] exp_pc);
        logic [31:0] c0;
        c0 = cycle_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_no_req", imem_req_valid, 1'b0);
        end
        chk("halt_cycle_frozen", cycle_cnt, c0);
        chk("halt_pc_frozen", pc, exp_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        next_pc = 32'h0; dec_illegal = 1'b0; dec_wb_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_rsp_ready", imem_rsp_ready, 1'b0);
        chk("rst_ex_start", ex_start, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_ir", ir, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_halt_code", halt_code, 2'd0);
        chk("rst_cycle", cycle_cnt, 32'h0);
        chk("rst_instret", instret_cnt, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // addi, zero-wait memory and single-cycle EXU
        addr_q.push_back(32'h8000_0000); ir_q.push_back(32'h0010_0093);
        wb_q.push_back('{32'h8000_0000, 1, 4});
        issue(32'h0010_0093, 32'h8000_0004, 1'b1, 1'b0, 0, 0);
        wait_done(32'd0, "addi");
        chk("addi_pc", pc, 32'h8000_0004);
        chk("addi_instret", instret_cnt, 32'd1);

        // request held off for 3 cycles with a stray response in the window
        addr_q.push_back(32'h8000_0004); ir_q.push_back(32'h0020_8113);
        wb_q.push_back('{32'h8000_0004, 1, 4});
        issue(32'h0020_8113, 32'h8000_0008, 1'b1, 1'b0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            rsp_force = (i == 1);
            @(negedge clk);
            chk("stall_req_valid", imem_req_valid, 1'b1);
            chk("stall_addr", imem_addr, 32'h8000_0004);
            chk("stall_rsp_ready", imem_rsp_ready, 1'b0);
            @(posedge clk); #1;
        end
        rsp_force = 1'b0;
        chk("stray_rsp_ignored", ir, 32'h0010_0093);
        wait_done(32'd1, "stall");
        chk("stall_pc", pc, 32'h8000_0008);
        chk("stall_instret", instret_cnt, 32'd2);

        // EXU busy for 3 extra cycles, then a jump-like next_pc
        addr_q.push_back(32'h8000_0008); ir_q.push_back(32'h0020_81b3);
        wb_q.push_back('{32'h8000_0008, 4, 7});
        issue(32'h0020_81b3, 32'h8000_0010, 1'b1, 1'b0, 0, 3);
        wait_done(32'd2, "exstall");
        chk("exstall_pc", pc, 32'h8000_0010);
        chk("exstall_instret", instret_cnt, 32'd3);

        // store: retires without a register write
        addr_q.push_back(32'h8000_0010); ir_q.push_back(32'h0011_2023);
        issue(32'h0011_2023, 32'h8000_0014, 1'b0, 1'b0, 0, 0);
        wait_done(32'd3, "store");
        chk("store_pc", pc, 32'h8000_0014);
        chk("store_instret", instret_cnt, 32'd4);

        // illegal instruction halts without retiring
        addr_q.push_back(32'h8000_0014);
        halt_q.push_back('{2'd3, 32'h8000_0014, 32'd4, 3});
        issue(32'hFFFF_FFFF, 32'h8000_0018, 1'b1, 1'b1, 0, 0);
        wait_done(32'd4, "illegal");
        chk("illegal_halted", halted, 1'b1);
        check_frozen(32'h8000_0014);

        // ebreak wins over dec_illegal and retires
        do_reset();
        addr_q.push_back(32'h8000_0000);
        halt_q.push_back('{2'd1, 32'h8000_0000, 32'd1, 3});
        issue(32'h0010_0073, 32'h8000_0004, 1'b1, 1'b1, 0, 0);
        wait_done(32'd0, "ebreak");
        chk("ebreak_halted", halted, 1'b1);
        check_frozen(32'h8000_0000);

        // memory never answers: timeout after 4 wait cycles
        do_reset();
        rsp_en = 1'b0;
        addr_q.push_back(32'h8000_0000);
        halt_q.push_back('{2'd2, 32'h8000_0000, 32'd0, 5});
        issue(32'h0010_0093, 32'h8000_0004, 1'b1, 1'b0, 0, 0);
        wait_done(32'd0, "timeout");
        chk("timeout_halted", halted, 1'b1);
        rsp_en = 1'b1;

        // reset pulse in the middle of a long EXECUTE
        do_reset();
        addr_q.push_back(32'h8000_0000); ir_q.push_back(32'h0010_0093);
        issue(32'h0010_0093, 32'h8000_0004, 1'b1, 1'b0, 0, 3);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ex_start && n < 30);
            chk("reach_execute", 64'(n < 30), 64'd1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wb_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pc", pc, RST_PC);
        chk("abort_ir", ir, 32'h0);
        chk("abort_cycle", cycle_cnt, 32'h0);
        chk("abort_instret", instret_cnt, 32'h0);
        chk("abort_fetch_req", imem_req_valid, 1'b1);
        chk("abort_addr", imem_addr, RST_PC);
        chk("abort_ex_start", ex_start, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_no_wb", rf_we, 1'b0);

        chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
        chk("ir_q_drained", 64'(ir_q.size()), 64'd0);
        chk("wb_q_drained", 64'(wb_q.size()), 64'd0);
        chk("halt_q_drained", 64'(halt_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/npc_seq_ctrl.md
Name: npc_seq_ctrl

Overview:
Multi-cycle sequencer for the NPC core. Owns the PC, issues instruction-fetch requests over a valid/ready instruction-memory interface and latches the returned instruction into an instruction register. Steps decode, execute and writeback by enable pulses to the IFU/IDU/EXU datapath. Detects ebreak, illegal instructions and fetch timeouts, halts the core, and keeps cycle and retired-instruction counters.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h8000_0000, PC value after reset
IMEM_TIMEOUT, 255, max FETCH_WAIT cycles before timeout halt (>=1)
CNT_W, 32, width of cycle/instret counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  instruction data valid
imem_rsp_ready  out  1  controller accepts response
imem_rdata  in  32  fetched instruction
ir  out  32  instruction register to IDU
pc  out  XLEN  current PC
next_pc  in  XLEN  next PC from execute/branch logic
dec_illegal  in  1  IDU flags ir as illegal
dec_wb_en  in  1  IDU: instruction writes rd
ex_start  out  1  one-cycle execute start pulse
ex_done  in  1  EXU result valid
rf_we  out  1  register-file write enable
halted  out  1  core stopped
halt_code  out  2  0 none, 1 ebreak, 2 fetch timeout, 3 illegal
cycle_cnt  out  CNT_W  cycles since reset while running
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (rst==0 at posedge): state=FETCH_REQ, pc=RESET_PC, ir=0, halted=0, halt_code=0, counters=0, timeout counter=0. All handshake/pulse outputs (imem_req_valid, imem_rsp_ready, ex_start, rf_we) are 0 during reset.
- Reset mid-operation aborts any outstanding fetch. The memory must drop requests abandoned by reset.
- FETCH_REQ: imem_req_valid=1, imem_addr=pc. Hold until imem_req_valid&&imem_req_ready. Then go to FETCH_WAIT and clear the timeout counter.
- FETCH_WAIT: imem_rsp_ready=1. A response can be accepted in the first FETCH_WAIT cycle. On imem_rsp_valid: ir<=imem_rdata and go to DECODE. Otherwise the timeout counter increments. When it reaches IMEM_TIMEOUT, go to HALT with halt_code=2.
- In any state other than FETCH_WAIT, imem_rsp_valid is ignored (imem_rsp_ready=0).
- DECODE (1 cycle):
  - ir==32'h0010_0073: go to HALT with halt_code=1 and instret+1.
  - Else if dec_illegal: go to HALT with halt_code=3 and no retire.
  - ebreak takes priority over dec_illegal.
  - Else go to EXECUTE.
- EXECUTE: ex_start=1 only in the first EXECUTE cycle. ex_done is sampled every EXECUTE cycle, including the first. When ex_done=1, go to WRITEBACK. A combinational EXU ties ex_done=1, giving a 1-cycle EXECUTE.
- WRITEBACK (1 cycle): rf_we=dec_wb_en. pc<=next_pc and instret+1 at the posedge. Then go to FETCH_REQ (or STEP_WAIT, see Optional Feature).
- HALT: terminal until reset. halted=1, halt_code held, pc/ir/counters frozen, all request/pulse outputs 0.
- Minimum latency: 5 cycles per instruction (REQ, WAIT, DECODE, EXECUTE, WRITEBACK).
- cycle_cnt increments every non-reset cycle while not in HALT. Both counters wrap modulo 2^CNT_W.
- pc is not alignment-checked. next_pc is taken as-is.

Optional Feature:
Macro NPC_SEQ_SINGLE_STEP_EN.
- Defined: adds input step_req (1 bit) and state STEP_WAIT. After WRITEBACK the FSM enters STEP_WAIT with all outputs idle. It moves to FETCH_REQ on the first cycle step_req=1. cycle_cnt still counts in STEP_WAIT. Out of reset, the FSM enters STEP_WAIT instead of FETCH_REQ.
- Undefined: no step_req port and no STEP_WAIT state. WRITEBACK goes directly to FETCH_REQ.

Test Plan:
- Release reset with imem_req_ready=1, rsp on next cycle with rdata=32'h0010_0093 (addi), next_pc=32'h8000_0004, dec_wb_en=1, ex_done=1 -> request at addr 0x80000000; rf_we single pulse in cycle 5; pc=0x80000004; instret_cnt=1.
- Hold imem_req_ready=0 for 3 cycles -> imem_req_valid stays 1 and imem_addr stable; imem_rsp_ready=0; an imem_rsp_valid pulse in that window is ignored (ir unchanged).
- Fetch 32'h0010_0073 -> halted=1, halt_code=1, instret_cnt=1, rf_we never asserted; imem_req_valid stays 0 and cycle_cnt frozen for 10 further cycles.
- IMEM_TIMEOUT=4, never assert imem_rsp_valid -> HALT with halt_code=2 after 4 FETCH_WAIT cycles; pc unchanged at 0x80000000.
- ex_done held low 3 cycles then high -> EXECUTE lasts 4 cycles, ex_start high only in the first; dec_illegal=1 on a separate instruction -> halt_code=3, instret unchanged.
- rst=0 for one cycle during EXECUTE -> next cycle pc=RESET_PC, ir=0, counters 0, FSM in FETCH_REQ. With NPC_SEQ_SINGLE_STEP_EN, the FSM stalls in STEP_WAIT until step_req=1, then one full instruction completes per step_req pulse.
